// File: rtl/iowrite_ctrl_if.sv
// Bus bundle for the buffered I/O write path: request side from memorio
// plus the per-device strobe/address/data side toward the peripherals.
interface iowrite_ctrl_if;
  logic        iowrite;
  logic        ledCtrl;
  logic        tubeCtrl;
  logic        timerCtrl;
  logic        pwmCtrl;
  logic [2:0]  ioaddr;
  logic [15:0] iowrite_data;
  logic [3:0]  dev_ready;
  logic        err_clear;
  logic        iowrite_full;
  logic        led_wen;
  logic        tube_wen;
  logic        timer_wen;
  logic        pwm_wen;
  logic [2:0]  dev_addr;
  logic [15:0] dev_data;
  logic [2:0]  err_status;

  modport master (
    output iowrite, ledCtrl, tubeCtrl, timerCtrl, pwmCtrl, ioaddr, iowrite_data,
           dev_ready, err_clear,
    input  iowrite_full, led_wen, tube_wen, timer_wen, pwm_wen, dev_addr,
           dev_data, err_status
  );

  modport slave (
    input  iowrite, ledCtrl, tubeCtrl, timerCtrl, pwmCtrl, ioaddr, iowrite_data,
           dev_ready, err_clear,
    output iowrite_full, led_wen, tube_wen, timer_wen, pwm_wen, dev_addr,
           dev_data, err_status
  );
endinterface

// File: rtl/iowrite_ctrl.sv
// Buffered memory-mapped I/O write path: queues iowrite requests in a FIFO
// and delivers each as a one-cycle strobe once the target device is ready.
module iowrite_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic         clock,
  input logic         reset,
  iowrite_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STROBE} state_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [2:0]  addr;
    logic [15:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic [TMR_W-1:0] r_timer;
  logic [1:0]       r_id;
  logic [2:0]       r_dev_addr;
  logic [15:0]      r_dev_data;
  logic [2:0]       r_err;
  state_t           r_state;

  state_t           w_state_next;
  logic [3:0]       w_sel;
  logic             w_one_hot;
  logic [1:0]       w_sel_id;
  logic             w_is_full;
  logic             w_has_entry;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic             w_timeout;
  logic             w_overflow;
  logic             w_bad_sel;
  logic [CNT_W-1:0] w_count_next;
  entry_t           w_head;

  assign w_sel       = {bus.pwmCtrl, bus.timerCtrl, bus.tubeCtrl, bus.ledCtrl};
  assign w_one_hot   = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
  assign w_is_full   = (r_count == FULL_CNT);
  assign w_has_entry = (r_count != '0);
  assign w_push      = bus.iowrite && w_one_hot && !w_is_full;
  assign w_overflow  = bus.iowrite && w_one_hot && w_is_full;
  assign w_bad_sel   = bus.iowrite && !w_one_hot;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_sel_id = 2'd0;
    if (w_sel[1]) w_sel_id = 2'd1;
    if (w_sel[2]) w_sel_id = 2'd2;
    if (w_sel[3]) w_sel_id = 2'd3;
  end

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_next = r_count - CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_has_entry) begin
          w_load       = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.dev_ready[r_id]) begin
          w_pop        = 1'b1;
          w_state_next = S_STROBE;
        end else if (r_timer == TMR_MAX) begin
          w_pop        = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_STROBE: begin
        // count already reflects the pop taken on entry to this state
        if (w_has_entry) begin
          w_load       = 1'b1;
          w_state_next = S_WAIT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: FIFO storage carries no reset; an entry is only ever read after the
  // count says it was written, so clearing it would buy nothing.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= '{id: w_sel_id, addr: bus.ioaddr, data: bus.iowrite_data};
  end

  // NOTE: state registers use non-blocking assignment so every register in the
  // block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_timer    <= '0;
      r_id       <= 2'd0;
      r_dev_addr <= 3'd0;
      r_dev_data <= 16'd0;
      r_err      <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);

      if (w_load) begin
        r_id       <= w_head.id;
        r_dev_addr <= w_head.addr;
        r_dev_data <= w_head.data;
        r_timer    <= '0;
      end else if (r_state == S_WAIT && !w_pop) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      // a set in the same cycle as a clear wins
      r_err <= (bus.err_clear ? 3'd0 : r_err) | {w_timeout, w_bad_sel, w_overflow};
    end
  end

  assign bus.iowrite_full = r_full;
  assign bus.dev_addr     = r_dev_addr;
  assign bus.dev_data     = r_dev_data;
  assign bus.err_status   = r_err;
  assign bus.led_wen      = (r_state == S_STROBE) && (r_id == 2'd0);
  assign bus.tube_wen     = (r_state == S_STROBE) && (r_id == 2'd1);
  assign bus.timer_wen    = (r_state == S_STROBE) && (r_id == 2'd2);
  assign bus.pwm_wen      = (r_state == S_STROBE) && (r_id == 2'd3);

endmodule

// File: tb/tb_iowrite_ctrl.sv
// Directed bench for iowrite_ctrl: reset, latency, burst/full/overflow,
// bad select, timeout, mid-operation reset and error set/clear collision.
module tb_iowrite_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iowrite_ctrl_if bus();

  iowrite_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // strobes ordered {pwm, timer, tube, led}
  function automatic logic [3:0] strobes();
    return {bus.pwm_wen, bus.timer_wen, bus.tube_wen, bus.led_wen};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iowrite      = 1'b0;
    bus.ledCtrl      = 1'b0;
    bus.tubeCtrl     = 1'b0;
    bus.timerCtrl    = 1'b0;
    bus.pwmCtrl      = 1'b0;
    bus.ioaddr       = 3'd0;
    bus.iowrite_data = 16'd0;
    bus.err_clear    = 1'b0;
  endtask

  // sel is {pwm, timer, tube, led}
  task automatic drive_write(input logic [3:0] sel, input logic [2:0] addr,
                             input logic [15:0] data);
    bus.iowrite      = 1'b1;
    bus.ledCtrl      = sel[0];
    bus.tubeCtrl     = sel[1];
    bus.timerCtrl    = sel[2];
    bus.pwmCtrl      = sel[3];
    bus.ioaddr       = addr;
    bus.iowrite_data = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.dev_ready = 4'h0;
    do_reset();
    checks++;
    if (strobes() !== 4'b0000) begin
      errors++; $display("FAIL reset_wen: got %b expected 0000", strobes());
    end
    checks++;
    if (bus.dev_addr !== 3'd0 || bus.dev_data !== 16'd0) begin
      errors++; $display("FAIL reset_dev: got addr %0d data %h expected 0/0000", bus.dev_addr, bus.dev_data);
    end
    checks++;
    if (bus.err_status !== 3'b000 || bus.iowrite_full !== 1'b0) begin
      errors++; $display("FAIL reset_status: got err %b full %b expected 000/0", bus.err_status, bus.iowrite_full);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.dev_ready = 4'hF;
    drive_write(4'b0010, 3'd2, 16'h1234);
    for (int i = 1; i <= 4; i++) begin
      step();
      idle_inputs();
      checks++;
      if (strobes() !== ((i == 3) ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL single_wen[%0d]: got %b expected %b", i, strobes(), (i == 3) ? 4'b0010 : 4'b0000);
      end
      if (i == 3) begin
        checks++;
        if (bus.dev_addr !== 3'd2 || bus.dev_data !== 16'h1234) begin
          errors++; $display("FAIL single_payload: got addr %0d data %h expected 2/1234", bus.dev_addr, bus.dev_data);
        end
      end
    end
  endtask

  task automatic test_burst_full();
    do_reset();
    bus.dev_ready = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      drive_write(4'b0001, 3'd0, 16'(k));
      step();
      if (k == 3) begin
        checks++;
        if (bus.iowrite_full !== 1'b0) begin
          errors++; $display("FAIL burst_not_full: got %b expected 0", bus.iowrite_full);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus.iowrite_full !== 1'b1) begin
          errors++; $display("FAIL burst_full: got %b expected 1", bus.iowrite_full);
        end
      end
    end
    idle_inputs();
    checks++;
    if (bus.err_status !== 3'b001) begin
      errors++; $display("FAIL burst_overflow: got %b expected 001", bus.err_status);
    end
    checks++;
    if (bus.dev_data !== 16'd1) begin
      errors++; $display("FAIL burst_head: got %h expected 0001", bus.dev_data);
    end
    bus.dev_ready = 4'b0001;
    for (int j = 1; j <= 8; j++) begin
      step();
      checks++;
      if (strobes() !== ((j % 2 == 1) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL burst_wen[%0d]: got %b expected %b", j, strobes(), (j % 2 == 1) ? 4'b0001 : 4'b0000);
      end
      if (j % 2 == 1) begin
        checks++;
        if (bus.dev_data !== 16'((j + 1) / 2)) begin
          errors++; $display("FAIL burst_data[%0d]: got %h expected %h", j, bus.dev_data, 16'((j + 1) / 2));
        end
      end
      if (j == 1) begin
        checks++;
        if (bus.iowrite_full !== 1'b0) begin
          errors++; $display("FAIL burst_full_fall: got %b expected 0", bus.iowrite_full);
        end
      end
    end
  endtask

  task automatic test_bad_select();
    do_reset();
    bus.dev_ready = 4'hF;
    drive_write(4'b1001, 3'd3, 16'hBEEF);
    step();
    drive_write(4'b0000, 3'd4, 16'hCAFE);
    step();
    idle_inputs();
    checks++;
    if (bus.err_status !== 3'b010) begin
      errors++; $display("FAIL badsel_err: got %b expected 010", bus.err_status);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (strobes() !== 4'b0000 || bus.dev_data !== 16'd0 || bus.iowrite_full !== 1'b0) begin
        errors++; $display("FAIL badsel_quiet[%0d]: got wen %b data %h full %b expected 0000/0000/0", i, strobes(), bus.dev_data, bus.iowrite_full);
      end
    end
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    checks++;
    if (bus.err_status !== 3'b000) begin
      errors++; $display("FAIL badsel_clear: got %b expected 000", bus.err_status);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.dev_ready = 4'b1000;
    drive_write(4'b0100, 3'd5, 16'hAAAA);
    step();
    drive_write(4'b1000, 3'd6, 16'h5555);
    step();
    idle_inputs();
    for (int j = 1; j <= 12; j++) begin
      step();
      checks++;
      if (strobes() !== ((j == 11) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL timeout_wen[%0d]: got %b expected %b", j, strobes(), (j == 11) ? 4'b1000 : 4'b0000);
      end
      if (j == 8) begin
        checks++;
        if (bus.err_status !== 3'b000 || bus.dev_data !== 16'hAAAA) begin
          errors++; $display("FAIL timeout_wait: got err %b data %h expected 000/aaaa", bus.err_status, bus.dev_data);
        end
      end
      if (j == 9) begin
        checks++;
        if (bus.err_status !== 3'b100) begin
          errors++; $display("FAIL timeout_err: got %b expected 100", bus.err_status);
        end
      end
      if (j == 11) begin
        checks++;
        if (bus.dev_addr !== 3'd6 || bus.dev_data !== 16'h5555) begin
          errors++; $display("FAIL timeout_pwm: got addr %0d data %h expected 6/5555", bus.dev_addr, bus.dev_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.dev_ready = 4'h0;
    for (int k = 0; k < 3; k++) begin
      drive_write(4'b0010, 3'd1, 16'h0011 * 16'(k + 1));
      step();
    end
    idle_inputs();
    step();
    checks++;
    if (bus.dev_data !== 16'h0011) begin
      errors++; $display("FAIL mid_head: got %h expected 0011", bus.dev_data);
    end
    reset = 1'b1;
    bus.dev_ready = 4'hF;
    step();
    reset = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (strobes() !== 4'b0000 || bus.dev_addr !== 3'd0 || bus.dev_data !== 16'd0 ||
          bus.err_status !== 3'b000 || bus.iowrite_full !== 1'b0) begin
        errors++; $display("FAIL mid_reset[%0d]: got wen %b addr %0d data %h err %b full %b expected all 0",
                           i, strobes(), bus.dev_addr, bus.dev_data, bus.err_status, bus.iowrite_full);
      end
      step();
    end
  endtask

  task automatic test_set_clear_collision();
    do_reset();
    bus.dev_ready = 4'h0;
    drive_write(4'b0000, 3'd0, 16'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive_write(4'b1000, 3'd7, 16'(16'h100 + k));
      step();
    end
    checks++;
    if (bus.err_status !== 3'b010 || bus.iowrite_full !== 1'b1) begin
      errors++; $display("FAIL collide_pre: got err %b full %b expected 010/1", bus.err_status, bus.iowrite_full);
    end
    drive_write(4'b1000, 3'd7, 16'h0200);
    bus.err_clear = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (bus.err_status !== 3'b001) begin
      errors++; $display("FAIL collide_err: got %b expected 001", bus.err_status);
    end
  endtask

  initial begin
    idle_inputs();
    bus.dev_ready = 4'h0;
    test_reset();
    test_single_write();
    test_burst_full();
    test_bad_select();
    test_timeout();
    test_reset_mid();
    test_set_clear_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
